// File: rtl/cpu_mem_pkg.sv
// cpu_mem_pkg: shared responder state encoding and default sizes
package cpu_mem_pkg;
  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    RD_WAIT = 3'd1,
    RD_DATA = 3'd2,
    WR_WAIT = 3'd3,
    WR_ACK  = 3'd4,
    HOLD    = 3'd5
  } state_t;
  localparam int ADDR_W_DEF = 8;
  localparam int DATA_W_DEF = 8;
  localparam int WAIT_DEF   = 2;
  localparam int MAX_WAIT   = 15;
  localparam int CNT_W      = $clog2(MAX_WAIT + 1);
endpackage

// File: rtl/data_mem_responder_if.sv
// data_mem_responder_if: strobe/ready handshake and instruction fetch signals
interface data_mem_responder_if #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 8
);
  logic [ADDR_W-1:0] ADDRESS;
  logic              MEM_READ;
  logic              MEM_WRITE;
  logic              MEM_READY;
  logic              MEM_ERR;
  logic [ADDR_W-1:0] INS_ADDRESS;
  logic [DATA_W-1:0] INS_BUS;
  modport master (
    output ADDRESS, MEM_READ, MEM_WRITE, INS_ADDRESS,
    input  MEM_READY, MEM_ERR, INS_BUS
  );
  modport slave (
    input  ADDRESS, MEM_READ, MEM_WRITE, INS_ADDRESS,
    output MEM_READY, MEM_ERR, INS_BUS
  );
endinterface

// File: rtl/mem_array_2r1w.sv
// mem_array_2r1w: unified storage, sync write, async data read, registered fetch read
module mem_array_2r1w #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata,
  input  logic [ADDR_W-1:0] iaddr,
  output logic [DATA_W-1:0] idata
);
  logic [DATA_W-1:0] mem [2**ADDR_W];
  always_ff @(posedge clk)
    if (we) mem[waddr] <= wdata;
  assign rdata = mem[raddr];
  // fetch samples the pre-write contents, so a same-edge write shows up one cycle later
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) idata <= '0;
    else idata <= mem[iaddr];
endmodule

// File: rtl/data_mem_responder.sv
// data_mem_responder: wait-stated byte memory responder with tristate data bus
// and an independent registered instruction fetch port on the same array.
module data_mem_responder
  import cpu_mem_pkg::*;
#(
  parameter int ADDR_W      = ADDR_W_DEF,
  parameter int DATA_W      = DATA_W_DEF,
  parameter int WAIT_STATES = WAIT_DEF
) (
  input  logic                  clk,
  input  logic                  rst_n,
  data_mem_responder_if.slave   bus,
  inout  wire  [DATA_W-1:0]     DATA_BUS
);
  state_t            state;
  logic [CNT_W-1:0]  cnt;
  logic [ADDR_W-1:0] addr_q, waddr;
  logic [DATA_W-1:0] wdata_q, wdata, rdata;
  logic              rd, wr, we, ready, oe, err;
  assign rd = bus.MEM_READ;
  assign wr = bus.MEM_WRITE;
  // the write lands on the edge entering WR_ACK; with no wait states that edge is still in IDLE
  always_comb begin
    we    = (state == IDLE && wr && !rd && WAIT_STATES == 0) ||
            (state == WR_WAIT && wr && cnt == CNT_W'(1));
    waddr = state == IDLE ? bus.ADDRESS : addr_q;
    wdata = state == IDLE ? DATA_BUS : wdata_q;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state   <= IDLE;
      cnt     <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      ready   <= 1'b0;
      oe      <= 1'b0;
      err     <= 1'b0;
    end else begin
      ready <= 1'b0;
      oe    <= 1'b0;
      case (state)
        IDLE:
          if (rd && wr) begin
            err   <= 1'b1;
            state <= HOLD;
          end else if (rd || wr) begin
            addr_q  <= bus.ADDRESS;
            wdata_q <= DATA_BUS;
            cnt     <= CNT_W'(WAIT_STATES);
            if (WAIT_STATES == 0) begin
              state <= rd ? RD_DATA : WR_ACK;
              ready <= 1'b1;
              oe    <= rd;
            end else state <= rd ? RD_WAIT : WR_WAIT;
          end
        RD_WAIT, WR_WAIT: begin
          cnt <= cnt - CNT_W'(1);
          if (!(state == RD_WAIT ? rd : wr)) state <= IDLE;
          else if (cnt == CNT_W'(1)) begin
            state <= state == RD_WAIT ? RD_DATA : WR_ACK;
            ready <= 1'b1;
            oe    <= state == RD_WAIT;
          end
        end
        RD_DATA, WR_ACK: state <= HOLD;
        HOLD: if (!rd && !wr) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  assign bus.MEM_READY = ready;
  assign bus.MEM_ERR   = err;
  assign DATA_BUS      = oe ? rdata : 'z;
  mem_array_2r1w #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_mem (
    .clk   (clk),
    .rst_n (rst_n),
    .we    (we),
    .waddr (waddr),
    .wdata (wdata),
    .raddr (addr_q),
    .rdata (rdata),
    .iaddr (bus.INS_ADDRESS),
    .idata (bus.INS_BUS)
  );
endmodule

// File: tb/tb_data_mem_responder.sv
// tb_data_mem_responder: directed checks of handshake, latency, fetch port and reset;
// a second instance with no wait states runs in lockstep on the same strobes.
module tb_data_mem_responder;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic tb_oe = 1'b0;
  logic [7:0] tb_wd = 8'h00;
  tri1 [7:0] data_bus;
  tri1 [7:0] data_bus0;
  int n_chk = 0;
  int n_fail = 0;
  data_mem_responder_if #(.ADDR_W(8), .DATA_W(8)) m ();
  data_mem_responder_if #(.ADDR_W(8), .DATA_W(8)) m0 ();
  assign m0.ADDRESS     = m.ADDRESS;
  assign m0.MEM_READ    = m.MEM_READ;
  assign m0.MEM_WRITE   = m.MEM_WRITE;
  assign m0.INS_ADDRESS = m.INS_ADDRESS;
  assign data_bus  = tb_oe ? tb_wd : 'z;
  assign data_bus0 = tb_oe ? tb_wd : 'z;
  always #5 clk = ~clk;
  data_mem_responder #(.ADDR_W(8), .DATA_W(8), .WAIT_STATES(2)) dut (
    .clk(clk), .rst_n(rst_n), .bus(m), .DATA_BUS(data_bus));
  data_mem_responder #(.ADDR_W(8), .DATA_W(8), .WAIT_STATES(0)) dut0 (
    .clk(clk), .rst_n(rst_n), .bus(m0), .DATA_BUS(data_bus0));
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  // one full access on the selected instance; undriven bus reads as 0xFF via the pull-up
  task automatic xfer(input bit sel, input logic rd, input logic wr, input logic [7:0] a,
                      input logic [7:0] d, input int lat, input logic [7:0] exp_rd, input string tag);
    int n = 0;
    m.ADDRESS = a; m.MEM_READ = rd; m.MEM_WRITE = wr; tb_oe = wr; tb_wd = d;
    do begin
      step();
      n++;
      if (rd && !(sel ? m0.MEM_READY : m.MEM_READY)) check({tag, "_z"}, sel ? data_bus0 : data_bus, 8'hFF);
    end while (!(sel ? m0.MEM_READY : m.MEM_READY) && n < 20);
    check({tag, "_lat"}, n, lat);
    if (rd) check({tag, "_data"}, sel ? data_bus0 : data_bus, exp_rd);
    m.MEM_READ = 1'b0; m.MEM_WRITE = 1'b0; tb_oe = 1'b0;
    step();
    check({tag, "_rdy_off"}, sel ? m0.MEM_READY : m.MEM_READY, 1'b0);
    if (rd) check({tag, "_z_after"}, sel ? data_bus0 : data_bus, 8'hFF);
    step();
  endtask
  initial begin
    int pulses;
    m.ADDRESS = '0; m.MEM_READ = 1'b0; m.MEM_WRITE = 1'b0; m.INS_ADDRESS = '0;
    step(); step();
    check("rst_ready", m.MEM_READY, 1'b0);
    check("rst_err", m.MEM_ERR, 1'b0);
    check("rst_ins", m.INS_BUS, 8'h00);
    check("rst_bus", data_bus, 8'hFF);
    rst_n = 1'b1;
    step();
    // write then read back
    xfer(1'b0, 1'b0, 1'b1, 8'h3C, 8'hA5, 3, 8'h00, "t1_wr");
    xfer(1'b0, 1'b1, 1'b0, 8'h3C, 8'h00, 3, 8'hA5, "t1_rd");
    // instruction fetch, including same-edge write
    xfer(1'b0, 1'b0, 1'b1, 8'h00, 8'h11, 3, 8'h00, "t2_w0");
    xfer(1'b0, 1'b0, 1'b1, 8'hFF, 8'h22, 3, 8'h00, "t2_wff");
    m.INS_ADDRESS = 8'h00;
    step();
    check("t2_ins00", m.INS_BUS, 8'h11);
    m.INS_ADDRESS = 8'hFF;
    step();
    check("t2_insff", m.INS_BUS, 8'h22);
    m.INS_ADDRESS = 8'h00;
    m.ADDRESS = 8'h00; m.MEM_WRITE = 1'b1; tb_oe = 1'b1; tb_wd = 8'h33;
    step(); step(); step();
    check("t2_wr_ready", m.MEM_READY, 1'b1);
    check("t2_ins_old", m.INS_BUS, 8'h11);
    m.MEM_WRITE = 1'b0; tb_oe = 1'b0;
    step();
    check("t2_ins_new", m.INS_BUS, 8'h33);
    step();
    // aborted write leaves memory untouched
    xfer(1'b0, 1'b0, 1'b1, 8'h10, 8'h5A, 3, 8'h00, "t3_pre");
    m.ADDRESS = 8'h10; m.MEM_WRITE = 1'b1; tb_oe = 1'b1; tb_wd = 8'h77;
    step();
    check("t3_rdy0", m.MEM_READY, 1'b0);
    m.MEM_WRITE = 1'b0; tb_oe = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      check("t3_no_rdy", m.MEM_READY, 1'b0);
    end
    xfer(1'b0, 1'b1, 1'b0, 8'h10, 8'h00, 3, 8'h5A, "t3_rd");
    // both strobes: sticky error, no access
    m.ADDRESS = 8'h20; m.MEM_READ = 1'b1; m.MEM_WRITE = 1'b1;
    step();
    check("t4_err", m.MEM_ERR, 1'b1);
    for (int i = 0; i < 4; i++) begin
      check("t4_no_rdy", m.MEM_READY, 1'b0);
      step();
    end
    m.MEM_READ = 1'b0; m.MEM_WRITE = 1'b0;
    step(); step();
    check("t4_err_held", m.MEM_ERR, 1'b1);
    xfer(1'b0, 1'b1, 1'b0, 8'h3C, 8'h00, 3, 8'hA5, "t4_rd");
    check("t4_err_after", m.MEM_ERR, 1'b1);
    // held strobe yields exactly one pulse
    pulses = 0;
    m.ADDRESS = 8'h00; m.MEM_READ = 1'b1;
    for (int i = 0; i < 10; i++) begin
      step();
      if (m.MEM_READY) pulses++;
    end
    check("t5_pulses", pulses, 1);
    m.MEM_READ = 1'b0;
    step(); step();
    // async reset in the read-data cycle
    m.ADDRESS = 8'hFF; m.MEM_READ = 1'b1;
    step(); step(); step();
    check("t6_ready", m.MEM_READY, 1'b1);
    check("t6_data", data_bus, 8'h22);
    #1 rst_n = 1'b0;
    #1;
    check("t6_rst_ready", m.MEM_READY, 1'b0);
    check("t6_rst_bus", data_bus, 8'hFF);
    check("t6_rst_ins", m.INS_BUS, 8'h00);
    check("t6_rst_err", m.MEM_ERR, 1'b0);
    m.MEM_READ = 1'b0;
    step();
    rst_n = 1'b1;
    step();
    // zero wait states: ready one cycle after the strobe
    xfer(1'b1, 1'b0, 1'b1, 8'h3C, 8'hC3, 1, 8'h00, "t6_w0_wr");
    xfer(1'b1, 1'b1, 1'b0, 8'h3C, 8'h00, 1, 8'hC3, "t6_w0_rd");
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/data_mem_responder.md
Name: data_mem_responder

Overview:
- Memory-side responder for the CPU datapath's memory interface.
- Services byte read/write requests presented on ADDRESS/DATA_BUS with strobes MEM_READ/MEM_WRITE (datapath M[1]/M[0]).
- Also supplies instruction bytes on INS_BUS for INS_ADDRESS from the same unified array.
- Configurable wait states, one-cycle MEM_READY pulse, strobe-release handshake, tristate bus ownership.

Parameters:
ADDR_W, 8, address width; array depth is 2**ADDR_W.
DATA_W, 8, data byte width.
WAIT_STATES, 2, extra cycles before a data access completes (legal 0..15).

Ports:
clk  input  1  system clock, all state on rising edge.
rst_n  input  1  asynchronous active-low reset.
ADDRESS  input  ADDR_W  data access address from datapath.
DATA_BUS  inout  DATA_W  write data in / read data out; driven only in RD_DATA.
MEM_READ  input  1  read strobe, level, held until MEM_READY seen.
MEM_WRITE  input  1  write strobe, level, held until MEM_READY seen.
MEM_READY  output  1  one-cycle completion pulse.
MEM_ERR  output  1  sticky protocol-error flag.
INS_ADDRESS  input  ADDR_W  instruction fetch address.
INS_BUS  output  DATA_W  instruction byte, registered.

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE, MEM_READY=0, MEM_ERR=0, INS_BUS=0x00, wait counter=0.
  - DATA_BUS released to high-Z immediately, not at the next edge.
  - Array contents are not reset.
- FSM states: IDLE, RD_WAIT, RD_DATA, WR_WAIT, WR_ACK, HOLD.
- IDLE:
  - MEM_READ=1 and MEM_WRITE=0: latch ADDRESS into addr_q, load cnt=WAIT_STATES. Go to RD_WAIT, or directly to RD_DATA if WAIT_STATES=0.
  - MEM_WRITE=1 and MEM_READ=0: latch ADDRESS into addr_q and DATA_BUS into wdata_q, load cnt. Go to WR_WAIT, or WR_ACK if WAIT_STATES=0.
  - Both strobes 1: set MEM_ERR=1, no access, go to HOLD.
- RD_WAIT / WR_WAIT:
  - cnt decrements each cycle.
  - When cnt reaches 1, next state is RD_DATA / WR_ACK.
  - If the active strobe drops before completion: abort, no write, return to IDLE.
- RD_DATA:
  - DATA_BUS = mem[addr_q] (read at the latched address).
  - MEM_READY=1 for exactly this cycle.
  - Next state HOLD.
- WR_ACK:
  - mem[addr_q] <= wdata_q on entry edge.
  - MEM_READY=1 this cycle.
  - Next state HOLD.
- HOLD:
  - Bus high-Z, MEM_READY=0.
  - Stay until MEM_READ=0 and MEM_WRITE=0, then go to IDLE.
  - A held strobe never re-triggers an access.
- Latency: strobe sampled in IDLE at edge N gives MEM_READY high during cycle N+WAIT_STATES+1.
- Back-to-back access minimum period: WAIT_STATES+3 cycles, because strobes must drop for at least one IDLE-sampled cycle.
- MEM_READY and DATA_BUS drive are decoded from registered state only. No combinational path from strobes to outputs.
- Instruction port:
  - INS_BUS <= mem[INS_ADDRESS] every cycle, 1-cycle latency, independent of the FSM.
  - Same-cycle write to INS_ADDRESS returns old data (read-before-write). New data appears the following cycle.
- Address width: full ADDR_W decode, no wrap logic needed; 0xFF is valid.
- MEM_ERR clears only on reset.

Decomposition:
- Shared package cpu_mem_pkg:
  - State enum/localparams (IDLE=0 .. HOLD=5, 3-bit encoding).
  - Default widths, MAX_WAIT=15.
- Sub-module mem_array_2r1w:
  - 2**ADDR_W x DATA_W storage.
  - One synchronous write port, one registered read port for instructions, one asynchronous read port for data.
- data_mem_responder contains the FSM, counter, latches and tristate driver.

Test Plan (WAIT_STATES=2 unless noted):
1. Write then read. Hold MEM_WRITE with ADDRESS=0x3C, DATA_BUS=0xA5 until ready, drop for 1 cycle, then read 0x3C. Required: ready 3 cycles after each strobe, and DATA_BUS=0xA5 only in the ready cycle, Z otherwise.
2. Instruction fetch. Write 0x11 to 0x00 and 0x22 to 0xFF, then INS_ADDRESS=0x00 then 0xFF on consecutive cycles. Required: INS_BUS=0x11 then 0x22, each one cycle later; same-cycle write to INS_ADDRESS shows old value first.
3. Abort. Drop MEM_WRITE (addr 0x10, data 0x77) one cycle after issue. Required: no MEM_READY; a later read of 0x10 returns its prior value.
4. Protocol error. Assert MEM_READ=MEM_WRITE=1. Required: MEM_ERR=1 next cycle and stays 1; no ready until strobes drop; a following normal read succeeds with MEM_ERR still 1.
5. Held strobe. Keep MEM_READ=1 for 10 cycles. Required: exactly one MEM_READY pulse.
6. Reset mid-read. Assert rst_n=0 in the RD_DATA cycle. Required: DATA_BUS goes Z and MEM_READY=0 without a clock edge, INS_BUS=0x00. Repeat test 1 with WAIT_STATES=0: required ready 1 cycle after strobe.
